// File: rtl/fir_mac_engine.sv
// Sequential NUM-tap FIR multiply-accumulate engine: one time-shared multiplier, one tap per clock.
// Optional output clamping to the signed BITS range is compiled in with `define FIR_SAT_EN.
module fir_mac_engine #(
    parameter int BITS     = 32,
    parameter int NUM      = 7,
    parameter int ACC_BITS = 67
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BITS-1:0]     coeff [NUM],
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_BITS-1:0] out_data,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // out_valid/out_data are held stable until taken, and in_ready never depends on in_valid.

    localparam int TAP_BITS = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [TAP_BITS-1:0] LAST_TAP = TAP_BITS'(NUM - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]          state;
    logic [BITS-1:0]     x_q      [NUM];
    logic [BITS-1:0]     shadow_q [NUM];
    logic [ACC_BITS-1:0] acc_q;
    logic [TAP_BITS-1:0] tap_q;
    logic [2*BITS-1:0]   prod;
    logic [ACC_BITS-1:0] acc_next;
    logic [ACC_BITS-1:0] result;

    assign in_ready  = reset_n && !clear && (state == S_IDLE);
    assign busy      = (state == S_MAC) || (state == S_OUT);
    assign state_dbg = state;

    // Operands are sign-extended to 2*BITS so the low half of the product is the signed product.
    always_comb begin
        prod = {{BITS{x_q[tap_q][BITS-1]}}, x_q[tap_q]} *
               {{BITS{shadow_q[tap_q][BITS-1]}}, shadow_q[tap_q]};
        acc_next = acc_q + {{(ACC_BITS-2*BITS){prod[2*BITS-1]}}, prod};
    end

`ifdef FIR_SAT_EN
    logic acc_neg;
    logic acc_fits;

    // The value fits when every bit from BITS-1 upward equals the sign bit.
    always_comb begin
        acc_neg  = acc_next[ACC_BITS-1];
        acc_fits = (&acc_next[ACC_BITS-1:BITS-1]) || !(|acc_next[ACC_BITS-1:BITS-1]);
        if (acc_fits) begin
            result = acc_next;
        end else begin
            result = {{(ACC_BITS-BITS+1){acc_neg}}, {(BITS-1){!acc_neg}}};
        end
    end
`else
    assign result = acc_next;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            acc_q     <= '0;
            tap_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < NUM; k++) begin
                x_q[k]      <= '0;
                shadow_q[k] <= '0;
            end
        end else if (clear) begin
            state     <= S_IDLE;
            acc_q     <= '0;
            tap_q     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < NUM; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q[0] <= in_data;
                        for (int k = 1; k < NUM; k++) begin
                            x_q[k] <= x_q[k-1];
                        end
                        for (int k = 0; k < NUM; k++) begin
                            shadow_q[k] <= coeff[k];
                        end
                        acc_q <= '0;
                        tap_q <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_next;
                    if (tap_q == LAST_TAP) begin
                        tap_q     <= '0;
                        out_data  <= result;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
